// File: rtl/fifo_serial_tx.sv
// Drains a FIFO one word per frame onto a single-wire async serial line.
// Frame format: start bit (0), DATA_W data bits LSB first, stop bit (1).
module fifo_serial_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              val,
    input  logic [DATA_W-1:0] datain,
    output logic              read,
    output logic              txd,
    output logic              busy
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              txd_next;
    logic              busy_next;
    logic              tick_done;

    assign tick_done = (tick_cnt == TICK_LAST);

    // txd and busy are registered from the next-state values so the start
    // bit appears on the line one cycle after the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            txd       <= txd_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        case (state)
            IDLE: begin
                if (read) begin
                    state_next = START;
                    shift_next = datain;
                    tick_next  = '0;
                    bit_next   = '0;
                end
            end
            START: begin
                if (tick_done) begin
                    state_next = DATA;
                    tick_next  = '0;
                    bit_next   = '0;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tick_done) begin
                    tick_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = STOP;
                        bit_next   = '0;
                    end else begin
                        shift_next = shift_reg >> 1;
                        bit_next   = bit_cnt + 1'b1;
                    end
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tick_done) begin
                    state_next = IDLE;
                    tick_next  = '0;
                end else begin
                    tick_next = tick_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    // Pop strobe is gated by reset so the FIFO never loses a word while held.
    always_comb begin
        read      = (state == IDLE) && val && reset;
        busy_next = (state_next != IDLE);
        txd_next  = 1'b1;
        case (state_next)
            IDLE:    txd_next = 1'b1;
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            STOP:    txd_next = 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: two instances (CLK_DIV=4 and CLK_DIV=1) fed by queue-based
// FIFO models and checked every cycle against a frame-position reference model.
module tb_fifo_serial_tx;

    localparam int DATA_W = 8;
    localparam int CD0    = 4;
    localparam int CD1    = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       val_in  [2];
    logic [7:0] data_in [2];
    logic       read_w  [2];
    logic       txd_w   [2];
    logic       busy_w  [2];

    int         pos   [2];
    logic [9:0] frame [2];
    int         cd    [2];
    bit         noise [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         rd0 [$];
    int         rd1 [$];
    int         cycle;
    int         checks;
    int         errors;
    int         c_start;

    always #5 clk = ~clk;

    fifo_serial_tx #(.DATA_W(DATA_W), .CLK_DIV(CD0)) dut0 (
        .clk    (clk),
        .reset  (reset),
        .val    (val_in[0]),
        .datain (data_in[0]),
        .read   (read_w[0]),
        .txd    (txd_w[0]),
        .busy   (busy_w[0])
    );

    fifo_serial_tx #(.DATA_W(DATA_W), .CLK_DIV(CD1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .val    (val_in[1]),
        .datain (data_in[1]),
        .read   (read_w[1]),
        .txd    (txd_w[1]),
        .busy   (busy_w[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, cycle);
        end
    endtask

    // One clock cycle: drive at negedge, check read, clock, advance model, check line.
    task automatic applyStimulus();
        logic       exp_read [2];
        logic       rd_obs   [2];
        int         qsize;
        logic [7:0] head;
        for (int i = 0; i < 2; i++) begin
            qsize = (i == 0) ? q0.size() : q1.size();
            head  = 8'($urandom);
            if (qsize != 0) head = (i == 0) ? q0[0] : q1[0];
            if (pos[i] != 0 && noise[i]) begin
                val_in[i]  = 1'($urandom);
                data_in[i] = 8'hFF;
            end else begin
                val_in[i]  = (qsize != 0);
                data_in[i] = head;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_read[i] = (pos[i] == 0) && val_in[i] && reset;
            rd_obs[i]   = read_w[i];
            checkOutput($sformatf("read%0d", i), 32'(rd_obs[i]), 32'(exp_read[i]));
        end
        @(posedge clk);
        cycle++;
        for (int i = 0; i < 2; i++) begin
            if (rd_obs[i]) begin
                if (i == 0 && q0.size() != 0) void'(q0.pop_front());
                if (i == 1 && q1.size() != 0) void'(q1.pop_front());
            end
            if (exp_read[i]) begin
                pos[i]   = 1;
                frame[i] = {1'b1, data_in[i], 1'b0};
                if (i == 0) rd0.push_back(cycle);
                else        rd1.push_back(cycle);
            end else if (pos[i] != 0) begin
                pos[i] = (pos[i] == (DATA_W + 2) * cd[i]) ? 0 : pos[i] + 1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("txd%0d", i), 32'(txd_w[i]),
                        32'((pos[i] == 0) ? 1'b1 : frame[i][(pos[i] - 1) / cd[i]]));
            checkOutput($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(pos[i] != 0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        cd[0] = CD0;
        cd[1] = CD1;
        for (int i = 0; i < 2; i++) begin
            pos[i]     = 0;
            noise[i]   = 1'b0;
            val_in[i]  = 1'b0;
            data_in[i] = 8'h00;
            frame[i]   = 10'h3FF;
        end
        reset = 1'b1;

        // Reset held with a word waiting: no pop, idle line.
        @(negedge clk);
        reset = 1'b0;
        q0.push_back(8'hA5);
        repeat (3) applyStimulus();
        checkOutput("rst_q_kept", 32'(q0.size()), 32'd1);

        // Release: A5 popped in the first idle cycle and sent once.
        reset = 1'b1;
        rd0.delete();
        c_start = cycle;
        repeat (45) applyStimulus();
        checkOutput("a5_reads", 32'(rd0.size()), 32'd1);
        if (rd0.size() == 1) checkOutput("a5_first", 32'(rd0[0]), 32'(c_start + 1));

        // Four preloaded words back to back.
        rd0.delete();
        q0.push_back(8'h01);
        q0.push_back(8'h02);
        q0.push_back(8'h03);
        q0.push_back(8'h04);
        repeat (4 * 41 + 8) applyStimulus();
        checkOutput("four_reads", 32'(rd0.size()), 32'd4);
        for (int k = 1; k < rd0.size(); k++)
            checkOutput("four_spacing", 32'(rd0[k] - rd0[k-1]), 32'd41);
        checkOutput("four_drained", 32'(q0.size()), 32'd0);

        // Mid-frame noise on val/datain must not disturb the 3C frame.
        q0.push_back(8'h3C);
        noise[0] = 1'b1;
        repeat (45) applyStimulus();
        noise[0] = 1'b0;

        // Async reset during data bit 3 of 5A; 11 follows, 5A is lost.
        q0.push_back(8'h5A);
        repeat (17) applyStimulus();
        checkOutput("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_txd", 32'(txd_w[0]), 32'd1);
        checkOutput("arst_busy", 32'(busy_w[0]), 32'd0);
        checkOutput("arst_read", 32'(read_w[0]), 32'd0);
        pos[0] = 0;
        pos[1] = 0;
        q0.push_back(8'h11);
        @(negedge clk);
        repeat (2) applyStimulus();
        reset = 1'b1;
        rd0.delete();
        c_start = cycle;
        repeat (45) applyStimulus();
        checkOutput("h11_reads", 32'(rd0.size()), 32'd1);
        if (rd0.size() == 1) checkOutput("h11_first", 32'(rd0[0]), 32'(c_start + 1));

        // CLK_DIV=1 instance: 80 then 7F back to back.
        rd1.delete();
        q1.push_back(8'h80);
        q1.push_back(8'h7F);
        repeat (30) applyStimulus();
        checkOutput("div1_reads", 32'(rd1.size()), 32'd2);
        if (rd1.size() == 2) checkOutput("div1_spacing", 32'(rd1[1] - rd1[0]), 32'd11);

        // Random words at random gaps on both instances, then drain.
        for (int r = 0; r < 10; r++) begin
            q0.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) q1.push_back(8'($urandom));
            repeat ($urandom_range(5, 60)) applyStimulus();
        end
        repeat (450) applyStimulus();
        checkOutput("rand_drain0", 32'(q0.size()), 32'd0);
        checkOutput("rand_drain1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
